// File: rtl/matrix_scan_scheduler_pkg.sv
// Shared types for the LED matrix scan scheduler: geometry, row/frame storage and scan states.
package matrix_pkg;
   localparam int MATRIX_ROWS = 8;
   localparam int MATRIX_COLS = 8;

   typedef logic [MATRIX_COLS-1:0] row_data_t;
   typedef row_data_t [MATRIX_ROWS-1:0] frame_t;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_e;
endpackage

// File: rtl/matrix_scan_scheduler_if.sv
// Producer/display bus of the matrix scan scheduler; test_mode exists only with MATRIX_SCAN_TEST_EN.
interface matrix_scan_scheduler_if;
   import matrix_pkg::*;

   logic       wr_en;
   logic [2:0] wr_row;
   row_data_t  wr_data;
   logic       swap_req;
   logic       swap_ack;
   logic [3:0] brightness;
   logic [7:0] row;
   row_data_t  col;
   logic       frame_start;
`ifdef MATRIX_SCAN_TEST_EN
   logic       test_mode;

   modport master (output wr_en, wr_row, wr_data, swap_req, brightness, test_mode,
                   input  swap_ack, row, col, frame_start);
   modport slave  (input  wr_en, wr_row, wr_data, swap_req, brightness, test_mode,
                   output swap_ack, row, col, frame_start);
`else
   modport master (output wr_en, wr_row, wr_data, swap_req, brightness,
                   input  swap_ack, row, col, frame_start);
   modport slave  (input  wr_en, wr_row, wr_data, swap_req, brightness,
                   output swap_ack, row, col, frame_start);
`endif
endinterface

// File: rtl/matrix_scan_scheduler_frame_buffer.sv
// Double-buffered 8x8 frame store: writes go to the back bank, reads come from the front bank.
module matrix_frame_buffer
   import matrix_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en_i,
   input  logic [2:0] wr_row_i,
   input  row_data_t  wr_data_i,
   input  logic       swap_i,
   input  logic [2:0] rd_row_i,
   output row_data_t  rd_data_o
);
   frame_t bank_q [2];
   frame_t bank_d [2];
   logic   front_sel_q;
   logic   front_sel_d;
   logic   back_sel_s;

   assign back_sel_s = ~front_sel_q;
   assign rd_data_o  = bank_q[front_sel_q][rd_row_i];

   // Write uses the pre-swap selection, so a write on the swap cycle lands in the new front.
   always_comb begin
      bank_d                       = bank_q;
      bank_d[back_sel_s][wr_row_i] = wr_en_i ? wr_data_i : bank_q[back_sel_s][wr_row_i];
      front_sel_d                  = swap_i ? ~front_sel_q : front_sel_q;
   end

   // Bank and selection registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]   <= '0;
         bank_q[1]   <= '0;
         front_sel_q <= 1'b0;
      end else begin
         bank_q      <= bank_d;
         front_sel_q <= front_sel_d;
      end
   end
endmodule

// File: rtl/matrix_scan_scheduler.sv
// Row scanner with blanking gap, 16-level PWM and frame-aligned buffer swap.
// Optional MATRIX_SCAN_TEST_EN adds test_mode, which lights every column during DRIVE.
module matrix_scan_scheduler
   import matrix_pkg::*;
#(
   parameter int CLK_PER_ROW  = 27000,
   parameter int BLANK_CYCLES = 64,
   parameter int ROWS         = MATRIX_ROWS,
   parameter int COLS         = MATRIX_COLS
) (
   input logic                   clk,
   input logic                   rst_n,
   matrix_scan_scheduler_if.slave bus
);
   localparam int SLOT_W = $clog2(CLK_PER_ROW);
   localparam int RIDX_W = $clog2(ROWS);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(CLK_PER_ROW - 1);
   localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
   localparam logic [RIDX_W-1:0] ROW_LAST   = RIDX_W'(ROWS - 1);

   scan_state_e       state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [RIDX_W-1:0] row_idx_q, row_idx_d;
   logic [3:0]        pwm_q, pwm_d;
   logic [3:0]        bright_q, bright_d;
   logic              pending_q, pending_d;
   logic [ROWS-1:0]   row_q, row_d;
   logic [COLS-1:0]   col_q, col_d;
   logic              frame_start_q, frame_start_d;
   logic              swap_ack_q, swap_ack_d;
   logic              swap_s;
   row_data_t         front_row_s;
   row_data_t         disp_row_s;

   matrix_frame_buffer u_frame_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (bus.wr_en),
      .wr_row_i  (bus.wr_row),
      .wr_data_i (bus.wr_data),
      .swap_i    (swap_s),
      .rd_row_i  (row_idx_d),
      .rd_data_o (front_row_s)
   );

`ifdef MATRIX_SCAN_TEST_EN
   assign disp_row_s = bus.test_mode ? 8'hFF : front_row_s;
`else
   assign disp_row_s = front_row_s;
`endif

   // Scan FSM, frame boundary handling and next output values.
   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q + SLOT_W'(1);
      row_idx_d     = row_idx_q;
      pwm_d         = pwm_q;
      bright_d      = bright_q;
      pending_d     = pending_q | bus.swap_req;
      swap_s        = 1'b0;
      frame_start_d = 1'b0;
      case (state_q)
         BLANK: begin
            if (slot_q == BLANK_LAST) begin
               state_d = DRIVE;
               pwm_d   = 4'd0;
            end else begin
               state_d = BLANK;
            end
         end
         DRIVE: begin
            pwm_d = pwm_q + 4'd1;
            if (slot_q == SLOT_LAST) begin
               state_d = BLANK;
               slot_d  = '0;
               if (row_idx_q == ROW_LAST) begin
                  // Frame boundary: latch brightness and apply any requested swap.
                  row_idx_d     = '0;
                  frame_start_d = 1'b1;
                  bright_d      = bus.brightness;
                  swap_s        = pending_q | bus.swap_req;
                  pending_d     = 1'b0;
               end else begin
                  row_idx_d = row_idx_q + RIDX_W'(1);
               end
            end else begin
               state_d = DRIVE;
            end
         end
         default: begin
            state_d = BLANK;
         end
      endcase
      swap_ack_d = swap_s;
      row_d      = (state_d == DRIVE) ? (ROWS'(1) << row_idx_d) : '0;
      col_d      = ((state_d == DRIVE) && (pwm_d <= bright_d)) ? disp_row_s : '0;
   end

   // State and registered outputs; row and col update on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BLANK;
         slot_q        <= '0;
         row_idx_q     <= '0;
         pwm_q         <= 4'd0;
         bright_q      <= 4'd15;
         pending_q     <= 1'b0;
         row_q         <= '0;
         col_q         <= '0;
         frame_start_q <= 1'b0;
         swap_ack_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         row_idx_q     <= row_idx_d;
         pwm_q         <= pwm_d;
         bright_q      <= bright_d;
         pending_q     <= pending_d;
         row_q         <= row_d;
         col_q         <= col_d;
         frame_start_q <= frame_start_d;
         swap_ack_q    <= swap_ack_d;
      end
   end

   assign bus.row         = row_q;
   assign bus.col         = col_q;
   assign bus.frame_start = frame_start_q;
   assign bus.swap_ack    = swap_ack_q;
endmodule

// File: doc/matrix_scan_scheduler.md
Name: matrix_scan_scheduler

Overview:
Sequences the 8x8 LED matrix: owns a double-buffered frame store, scans rows with a blanking gap between rows to prevent ghosting, and applies 16-level PWM brightness.
- Producers write the back buffer and request a swap; the swap is applied only at a frame boundary, so no frame is ever displayed torn.
- Outputs feed the anode tristate enables and cathode pins at top level.

Parameters:
CLK_PER_ROW, 27000, clk cycles per row slot (blank + drive); must be > BLANK_CYCLES + 16.
BLANK_CYCLES, 64, cycles per slot with row and col forced to 0.
ROWS, 8, matrix rows (row index width $clog2(ROWS)).
COLS, 8, matrix columns.

Ports:
clk  in  1  system clock (27 MHz)
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe into the back buffer
wr_row  in  3  row address of write
wr_data  in  8  column bits for that row; bit i = column i
swap_req  in  1  single-cycle pulse requesting a buffer swap
swap_ack  out  1  single-cycle pulse when the swap is applied
brightness  in  4  duty level 0..15, giving (brightness+1)/16 on-time
row  out  8  one-hot active-high row enable
col  out  8  column drive, active-high
frame_start  out  1  single-cycle pulse at the start of row 0

Behaviour:
- Reset (async assert, sync release):
  - row, col, swap_ack and frame_start = 0.
  - State = BLANK, row_idx = 0, slot counter = 0, pwm_phase = 0.
  - front_sel = 0, swap pending = 0, both buffers all-zero.
  - Active brightness register = 15.
- States:
  - BLANK: lasts BLANK_CYCLES cycles; row = 0, col = 0. Then go to DRIVE.
  - DRIVE: lasts CLK_PER_ROW - BLANK_CYCLES cycles; row = 1 << row_idx.
    - col = front[row_idx] when pwm_phase < active_brightness + 1, else 0.
    - pwm_phase is a 4-bit counter, cleared on DRIVE entry, +1 per cycle, wraps 15 -> 0.
- End of DRIVE: row_idx advances (7 -> 0 wrap), state returns to BLANK, slot counter clears.
- Frame boundary = the DRIVE -> BLANK transition when row_idx = 7. In that cycle:
  - frame_start = 1 the following cycle.
  - active_brightness <= brightness. Brightness changes mid-frame have no effect until the next boundary.
  - If swap pending, or swap_req is high in that same cycle: front_sel toggles, pending clears, swap_ack = 1 the following cycle.
- swap_req at any other cycle sets pending. A repeat while pending is absorbed, giving one swap and one ack.
- Writes:
  - wr_en writes wr_data to back[wr_row] (back = !front_sel) with the pre-swap selection.
  - A write coinciding with the swap cycle lands in the buffer that becomes front; producers must wait for swap_ack before writing the next frame.
  - Writes never alter the displayed buffer otherwise.
  - wr_row is always in range for ROWS = 8; no out-of-range handling is needed.
- All outputs are registered and glitch-free; row is never multi-hot. row and col both change on the same edge.
- Frame period = ROWS * CLK_PER_ROW cycles (216000 at defaults, 125 Hz).
- rst_n asserted mid-frame: immediate return to reset values; buffer contents are lost.

Optional Feature:
MATRIX_SCAN_TEST_EN
- Defined: adds input test_mode (1 bit). When 1, col = 8'hFF during DRIVE (PWM gating still applies), the buffers are ignored for display, and writes/swaps continue normally.
- Undefined: no test_mode port; display always from the front buffer.

Decomposition:
Package matrix_pkg:
- MATRIX_ROWS = 8, MATRIX_COLS = 8.
- Typedefs row_data_t (logic [7:0]) and frame_t (row_data_t [7:0]).
- scan_state_e {BLANK, DRIVE}.

One sub-module, matrix_frame_buffer:
- Two frame_t registers, front_sel and the write port.
- Swap input; combinational read of the front row by index.
- Scheduler FSM, PWM and handshake stay in matrix_scan_scheduler.

Test Plan:
1. CLK_PER_ROW=40, BLANK_CYCLES=4, brightness=15, back row3=8'hA5, swap pulse.
   -> swap_ack exactly one cycle after the row7->BLANK boundary; next frame row=8'h08, col=8'hA5 for 36 cycles, preceded by 4 cycles of row=0, col=0.
2. brightness=3, row0 data 8'hFF.
   -> in each 16-cycle PWM window col=8'hFF for 4 cycles and 0 for 12; brightness changed to 0 mid-frame takes effect only after the next frame_start.
3. swap_req pulsed 3 times within one frame.
   -> exactly one swap_ack and a single front_sel toggle; swap_req on the boundary cycle itself swaps in that same frame.
4. Write 8'h3C to row 5 with no swap.
   -> display unchanged (front still 0); after swap, row5 shows 8'h3C.
5. Assert rst_n low during DRIVE of row 4.
   -> row=0, col=0, swap_ack=0 immediately; after release, row0 BLANK restarts, no frame_start until first wrap.
6. With MATRIX_SCAN_TEST_EN, test_mode=1, empty buffers.
   -> col=8'hFF during every DRIVE; row stays one-hot across a full 8-row scan.
